// File: rtl/dram_ctrl.sv
// rtl/dram_ctrl.sv - MEM-stage load/store bus master (IDLE/BUSY/DONE); optional timeout under DRAM_TIMEOUT_EN
module dram_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  sel_i,
   output logic [31:0] data_o,
   output logic        stall_o,
   output logic        err_o,
   output logic        bus_cyc_o,
   output logic        bus_stb_o,
   output logic        bus_we_o,
   output logic [31:0] bus_adr_o,
   output logic [31:0] bus_dat_o,
   output logic [3:0]  bus_sel_o,
   input  logic [31:0] bus_dat_i,
   input  logic        bus_ack_i
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t state;

`ifdef DRAM_TIMEOUT_EN
   logic [7:0] wait_cnt;
`else
   assign err_o = 1'b0;
`endif

   // hold the pipeline while a request is being accepted or is on the bus; never during reset
   assign stall_o = !rst && ((state == IDLE && req_i) || state == BUSY);

   // request FSM; the bus output registers double as the latched request
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         data_o    <= 32'd0;
         bus_cyc_o <= 1'b0;
         bus_stb_o <= 1'b0;
         bus_we_o  <= 1'b0;
         bus_adr_o <= 32'd0;
         bus_dat_o <= 32'd0;
         bus_sel_o <= 4'd0;
`ifdef DRAM_TIMEOUT_EN
         wait_cnt  <= 8'd0;
         err_o     <= 1'b0;
`endif
      end else begin
`ifdef DRAM_TIMEOUT_EN
         err_o <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (req_i) begin
                  bus_we_o  <= we_i;
                  bus_adr_o <= addr_i & 32'hFFFF_FFFC;
                  bus_dat_o <= wdata_i;
                  bus_sel_o <= sel_i;
                  bus_cyc_o <= 1'b1;
                  bus_stb_o <= 1'b1;
`ifdef DRAM_TIMEOUT_EN
                  wait_cnt  <= 8'd0;
`endif
                  state     <= BUSY;
               end
            end
            BUSY: begin
               // an ack always wins over a timeout in the same cycle
               if (bus_ack_i) begin
                  if (!bus_we_o) begin
                     data_o <= bus_dat_i;
                  end
                  bus_cyc_o <= 1'b0;
                  bus_stb_o <= 1'b0;
                  state     <= DONE;
               end
`ifdef DRAM_TIMEOUT_EN
               else if (wait_cnt == 8'hFF) begin
                  bus_cyc_o <= 1'b0;
                  bus_stb_o <= 1'b0;
                  data_o    <= 32'd0;
                  err_o     <= 1'b1;
                  state     <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
`endif
            end
            DONE: begin
               // a request seen here is the instruction just completed; do not re-issue it
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dram_ctrl.sv
// tb/tb_dram_ctrl.sv - self-checking bench for dram_ctrl (vector table, corner sequences, random transactions)
module tb_dram_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [3:0]  sel_i;
   logic [31:0] data_o;
   logic        stall_o;
   logic        err_o;
   logic        bus_cyc_o;
   logic        bus_stb_o;
   logic        bus_we_o;
   logic [31:0] bus_adr_o;
   logic [31:0] bus_dat_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_dat_i;
   logic        bus_ack_i;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_starts = 0;
   logic cyc_q = 1'b0;
   logic [31:0] model_data;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      logic [31:0] rdata;
      int          waits;
      logic        hold;
      logic [31:0] exp_adr;
      logic [31:0] exp_data;
      int          exp_stalls;
   } vec_t;

   vec_t vecs[4];

   dram_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req_i),
      .we_i      (we_i),
      .addr_i    (addr_i),
      .wdata_i   (wdata_i),
      .sel_i     (sel_i),
      .data_o    (data_o),
      .stall_o   (stall_o),
      .err_o     (err_o),
      .bus_cyc_o (bus_cyc_o),
      .bus_stb_o (bus_stb_o),
      .bus_we_o  (bus_we_o),
      .bus_adr_o (bus_adr_o),
      .bus_dat_o (bus_dat_o),
      .bus_sel_o (bus_sel_o),
      .bus_dat_i (bus_dat_i),
      .bus_ack_i (bus_ack_i)
   );

   always #5 clk = ~clk;

   // count bus cycle starts (rising edges of bus_cyc_o)
   always @(posedge clk) begin
      cyc_q <= bus_cyc_o;
      if (bus_cyc_o && !cyc_q) cyc_starts <= cyc_starts + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // one full transaction starting from IDLE; the bench acts as the bus slave
   task automatic run_txn(input vec_t v, input string tag);
      int stalls;
      stalls = 0;
      @(negedge clk);
      req_i = 1'b1; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata; sel_i = v.sel;
      bus_ack_i = 1'b0; bus_dat_i = $urandom;
      #1;
      chk({tag, ".idle_cyc"}, 32'(bus_cyc_o), 32'd0);
      stalls += int'(stall_o);
      for (int k = 0; k <= v.waits; k++) begin
         @(negedge clk);
         bus_ack_i = (k == v.waits);
         bus_dat_i = (k == v.waits) ? v.rdata : $urandom;
         addr_i = $urandom; wdata_i = $urandom; sel_i = 4'($urandom); we_i = 1'($urandom);
         #1;
         stalls += int'(stall_o);
         chk({tag, ".cyc"}, 32'(bus_cyc_o), 32'd1);
         chk({tag, ".stb"}, 32'(bus_stb_o), 32'd1);
         chk({tag, ".adr"}, bus_adr_o, v.exp_adr);
         chk({tag, ".we"},  32'(bus_we_o), 32'(v.we));
         chk({tag, ".sel"}, 32'(bus_sel_o), 32'(v.sel));
         chk({tag, ".dat"}, bus_dat_o, v.wdata);
      end
      @(negedge clk);
      req_i = v.hold; bus_ack_i = 1'b0; bus_dat_i = $urandom;
      #1;
      chk({tag, ".done_stall"}, 32'(stall_o), 32'd0);
      chk({tag, ".done_cyc"}, 32'(bus_cyc_o), 32'd0);
      chk({tag, ".done_stb"}, 32'(bus_stb_o), 32'd0);
      chk({tag, ".data"}, data_o, v.exp_data);
      chk({tag, ".err"}, 32'(err_o), 32'd0);
      chk({tag, ".stalls"}, 32'(stalls), 32'(v.exp_stalls));
   endtask

   initial begin
      vecs[0] = '{we:1'b0, addr:32'h0000_1006, wdata:32'h0, sel:4'hF, rdata:32'hDEAD_BEEF, waits:0,
                  hold:1'b1, exp_adr:32'h0000_1004, exp_data:32'hDEAD_BEEF, exp_stalls:2};
      vecs[1] = '{we:1'b1, addr:32'h0000_2000, wdata:32'h1234_5678, sel:4'b0011, rdata:32'h5555_AAAA, waits:3,
                  hold:1'b0, exp_adr:32'h0000_2000, exp_data:32'hDEAD_BEEF, exp_stalls:5};
      vecs[2] = '{we:1'b0, addr:32'hFFFF_FFFF, wdata:32'h0, sel:4'b0001, rdata:32'h0000_00A5, waits:1,
                  hold:1'b0, exp_adr:32'hFFFF_FFFC, exp_data:32'h0000_00A5, exp_stalls:3};
      vecs[3] = '{we:1'b1, addr:32'h0000_0003, wdata:32'hCAFE_F00D, sel:4'b1000, rdata:32'h1111_2222, waits:0,
                  hold:1'b0, exp_adr:32'h0000_0000, exp_data:32'h0000_00A5, exp_stalls:2};

      // reset with a pending request: everything zero, no stall
      rst = 1'b1; req_i = 1'b1; we_i = 1'b1; addr_i = 32'hFFFF_FFFF; wdata_i = 32'hFFFF_FFFF;
      sel_i = 4'hF; bus_dat_i = 32'hFFFF_FFFF; bus_ack_i = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst.stall", 32'(stall_o), 32'd0);
      chk("rst.data", data_o, 32'd0);
      chk("rst.cyc", 32'(bus_cyc_o), 32'd0);
      chk("rst.adr", bus_adr_o, 32'd0);
      chk("rst.err", 32'(err_o), 32'd0);
      @(negedge clk);
      rst = 1'b0; req_i = 1'b0; bus_ack_i = 1'b0;
      model_data = 32'd0;

      // directed vector table: load, back-to-back store, unaligned load, store at low address
      for (int i = 0; i < 4; i++) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
         model_data = vecs[i].exp_data;
         if (i == 1) chk("b2b.bus_cycles", 32'(cyc_starts), 32'd2);
      end

      // ack while idle with no request is ignored
      @(negedge clk);
      req_i = 1'b0; bus_ack_i = 1'b1; bus_dat_i = 32'h0BAD_0BAD;
      #1;
      chk("idle_ack.stall", 32'(stall_o), 32'd0);
      @(negedge clk);
      bus_ack_i = 1'b0;
      #1;
      chk("idle_ack.cyc", 32'(bus_cyc_o), 32'd0);
      chk("idle_ack.data", data_o, model_data);

      // reset in the second BUSY cycle aborts the bus cycle
      @(negedge clk);
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0040; sel_i = 4'hF; bus_ack_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_busy.stall_in_rst", 32'(stall_o), 32'd0);
      @(negedge clk);
      rst = 1'b0; req_i = 1'b0;
      #1;
      chk("rst_busy.cyc", 32'(bus_cyc_o), 32'd0);
      chk("rst_busy.stb", 32'(bus_stb_o), 32'd0);
      chk("rst_busy.data", data_o, 32'd0);
      chk("rst_busy.stall", 32'(stall_o), 32'd0);
      chk("rst_busy.err", 32'(err_o), 32'd0);
      model_data = 32'd0;

`ifdef DRAM_TIMEOUT_EN
      // no ack: bus cycle aborted after the counter reaches 255, one err pulse
      begin
         int busy, errs, dropped;
         busy = 0; errs = 0; dropped = 0;
         @(negedge clk);
         req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0080; sel_i = 4'hF; bus_ack_i = 1'b0;
         for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req_i = (dropped == 0);
            #1;
            if (bus_cyc_o) busy++;
            errs += int'(err_o);
            if (!bus_cyc_o && dropped == 0) begin
               dropped = 1;
               chk("tmo.data", data_o, 32'd0);
               chk("tmo.stall", 32'(stall_o), 32'd0);
            end
         end
         chk("tmo.dropped", 32'(dropped), 32'd1);
         chk("tmo.busy_cycles", 32'(busy), 32'd256);
         chk("tmo.err_pulses", 32'(errs), 32'd1);
         model_data = 32'd0;
      end
`else
      // no ack: BUSY waits indefinitely without error, then completes on a late ack
      begin
         int idle_seen, errs;
         vec_t lv;
         idle_seen = 0; errs = 0;
         lv = '{we:1'b0, addr:32'h0000_0080, wdata:32'h0, sel:4'hF, rdata:32'h7777_8888, waits:300,
                hold:1'b0, exp_adr:32'h0000_0080, exp_data:32'h7777_8888, exp_stalls:302};
         run_txn(lv, "long_wait");
         model_data = lv.exp_data;
      end
`endif

      // randomized transactions against a transaction-level model
      for (int i = 0; i < 40; i++) begin
         vec_t v;
         v.we         = 1'($urandom);
         v.addr       = $urandom;
         v.wdata      = $urandom;
         v.sel        = 4'($urandom);
         v.rdata      = $urandom;
         v.waits      = int'($urandom_range(0, 4));
         v.hold       = 1'($urandom);
         v.exp_adr    = {v.addr[31:2], 2'b00};
         v.exp_data   = v.we ? model_data : v.rdata;
         v.exp_stalls = v.waits + 2;
         run_txn(v, $sformatf("rnd%0d", i));
         model_data = v.exp_data;
      end

      @(negedge clk);
      req_i = 1'b0;
      #1;
      chk("final.cyc", 32'(bus_cyc_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
